// File: rtl/display_pkg.sv
// Shared constants, FSM encoding and decimal-point helper for the
// binary-to-BCD converter that feeds the 4-digit seven-segment driver.
package display_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BIN_W      = 14;
    localparam int CNT_W      = 4;

    localparam logic [BIN_W-1:0] MAX_VAL  = 14'd9999;
    localparam logic [CNT_W-1:0] CNT_LAST = 4'd13;   // counter value on the 14th shift
    localparam logic [3:0]       DP_OFF   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Active-low one-hot point enable for the selected digit, or all off.
    function automatic logic [3:0] dp_decode(input logic [1:0] sel, input logic en);
        logic [3:0] onehot;
        onehot = 4'b0001 << sel;
        return en ? ~onehot : DP_OFF;
    endfunction

endpackage

// File: rtl/dabble_adjust.sv
// One double-dabble correction step: a BCD nibble of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module dabble_adjust (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // 4-bit add with no carry out; inputs never exceed 9 so nothing is lost.
    always_comb begin
        nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;
    end

endmodule

// File: rtl/bcd_convert_x_4.sv
// Sequential binary-to-BCD converter: accepts a 14-bit value over
// valid/ready, clamps it to 9999, runs one double-dabble shift per clock
// and commits four BCD digits plus decimal-point enables in one edge.
module bcd_convert_x_4
    import display_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic [1:0]       dp_sel,
    input  logic             dp_en,
    input  logic             bin_valid,
    output logic             bin_ready,
    output logic [15:0]      bcd_out,
    output logic [3:0]       decimal_points,
    output logic             overflow,
    output logic             bcd_valid
);

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dp_sel_q, dp_sel_d;
    logic             dp_en_q, dp_en_d;
    logic             clamp_q, clamp_d;
    logic [15:0]      bcd_out_q, bcd_out_d;
    logic [3:0]       dp_out_q, dp_out_d;
    logic             overflow_q, overflow_d;
    logic             bcd_valid_q, bcd_valid_d;

    logic [15:0]      scratch_adj;

    // Per-digit add-3 correction applied before every shift.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
            dabble_adjust u_adj (
                .nib_in  (scratch_q[gi*4 +: 4]),
                .nib_out (scratch_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Next-state and datapath: capture on accept, shift in CONV, commit in DONE.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        dp_sel_d    = dp_sel_q;
        dp_en_d     = dp_en_q;
        clamp_d     = clamp_q;
        bcd_out_d   = bcd_out_q;
        dp_out_d    = dp_out_q;
        overflow_d  = overflow_q;
        bcd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bin_valid) begin
                    clamp_d   = (bin_in > MAX_VAL);
                    bin_d     = (bin_in > MAX_VAL) ? MAX_VAL : bin_in;
                    dp_sel_d  = dp_sel;
                    dp_en_d   = dp_en;
                    scratch_d = 16'h0000;
                    cnt_d     = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                {scratch_d, bin_d} = {scratch_adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_out_d   = scratch_q;
                dp_out_d    = dp_decode(dp_sel_q, dp_en_q);
                overflow_d  = clamp_q;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            scratch_q   <= 16'h0000;
            cnt_q       <= '0;
            dp_sel_q    <= 2'd0;
            dp_en_q     <= 1'b0;
            clamp_q     <= 1'b0;
            bcd_out_q   <= 16'h0000;
            dp_out_q    <= DP_OFF;
            overflow_q  <= 1'b0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            dp_sel_q    <= dp_sel_d;
            dp_en_q     <= dp_en_d;
            clamp_q     <= clamp_d;
            bcd_out_q   <= bcd_out_d;
            dp_out_q    <= dp_out_d;
            overflow_q  <= overflow_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bin_ready      = (state_q == ST_IDLE);
    assign bcd_out        = bcd_out_q;
    assign decimal_points = dp_out_q;
    assign overflow       = overflow_q;
    assign bcd_valid      = bcd_valid_q;

endmodule

// File: tb/tb_bcd_convert_x_4.sv
// Randomised and directed bench for bcd_convert_x_4 against a decimal
// arithmetic reference model.
module tb_bcd_convert_x_4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] bin_in = '0;
    logic [1:0]  dp_sel = '0;
    logic        dp_en = 1'b0;
    logic        bin_valid = 1'b0;
    logic        bin_ready;
    logic [15:0] bcd_out;
    logic [3:0]  decimal_points;
    logic        overflow;
    logic        bcd_valid;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bcd_convert_x_4 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bin_in         (bin_in),
        .dp_sel         (dp_sel),
        .dp_en          (dp_en),
        .bin_valid      (bin_valid),
        .bin_ready      (bin_ready),
        .bcd_out        (bcd_out),
        .decimal_points (decimal_points),
        .overflow       (overflow),
        .bcd_valid      (bcd_valid)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits of the clamped value.
    function automatic logic [15:0] exp_bcd(input int x);
        int v;
        v = (x > 9999) ? 9999 : x;
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] exp_dp(input int sel, input bit en);
        return en ? 4'(15 - (1 << sel)) : 4'hF;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one request and wait for its result; returns latency and the
    // number of sampled cycles with bin_ready low. after_v >= 0 replaces
    // bin_in (and scrambles dp inputs) right after the accept edge.
    task automatic send(input int v, input int sel, input bit en, input int after_v,
                        output int lat, output int rdy_low);
        for (int i = 0; i < 40 && !bin_ready; i++) step();
        if (!bin_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=%0b want=1", bin_ready);
        end
        bin_in    = 14'(v);
        dp_sel    = 2'(sel);
        dp_en     = en;
        bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        if (after_v >= 0) begin
            bin_in = 14'(after_v);
            dp_sel = ~dp_sel;
            dp_en  = ~dp_en;
        end
        lat = 0;
        rdy_low = bin_ready ? 0 : 1;
        for (int i = 0; i < 40; i++) begin
            step();
            lat++;
            if (!bin_ready) rdy_low++;
            if (bcd_valid) break;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bcd_out !== 16'h0000 || decimal_points !== 4'hF || overflow !== 1'b0 ||
            bcd_valid !== 1'b0 || bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got=%h/%b/%b/%b/%b want=0000/1111/0/0/1",
                     bcd_out, decimal_points, overflow, bcd_valid, bin_ready);
        end
        $display("test_reset bcd=%h dp=%b ready=%b", bcd_out, decimal_points, bin_ready);
    endtask

    task automatic test_basic();
        int lat, rl;
        send(1234, 0, 1'b0, -1, lat, rl);
        checks++;
        if (lat !== 15) begin failures++; $display("FAIL basic_latency got=%0d want=15", lat); end
        checks++;
        if (rl !== 15) begin failures++; $display("FAIL basic_ready_low got=%0d want=15", rl); end
        checks++;
        if (bcd_out !== 16'h1234 || decimal_points !== 4'hF || overflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_out got=%h/%b/%b want=1234/1111/0", bcd_out, decimal_points, overflow);
        end
        step();
        checks++;
        if (bcd_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width got=%b want=0", bcd_valid); end
        checks++;
        if (bcd_out !== 16'h1234) begin failures++; $display("FAIL basic_hold got=%h want=1234", bcd_out); end
        $display("test_basic in=1234 bcd=%h lat=%0d ready_low=%0d", bcd_out, lat, rl);
    endtask

    task automatic test_back_to_back();
        int acc [2];
        logic [15:0] res [2];
        logic ovf [2];
        int k = 0;
        int r = 0;
        dp_en     = 1'b0;
        bin_in    = 14'd0;
        bin_valid = 1'b1;
        for (int i = 0; i < 60 && r < 2; i++) begin
            if (bin_ready && k < 2) begin acc[k] = cyc; k++; end
            step();
            if (k == 1) bin_in = 14'd9999;
            if (k == 2) bin_valid = 1'b0;
            if (bcd_valid) begin res[r] = bcd_out; ovf[r] = overflow; r++; end
        end
        bin_valid = 1'b0;
        checks++;
        if (r !== 2 || k !== 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d/%0d want=2/2", k, r);
        end else begin
            checks++;
            if (acc[1] - acc[0] !== 16) begin
                failures++; $display("FAIL b2b_spacing got=%0d want=16", acc[1] - acc[0]);
            end
            checks++;
            if (res[0] !== 16'h0000 || ovf[0] !== 1'b0) begin
                failures++; $display("FAIL b2b_zero got=%h/%b want=0000/0", res[0], ovf[0]);
            end
            checks++;
            if (res[1] !== 16'h9999 || ovf[1] !== 1'b0) begin
                failures++; $display("FAIL b2b_max got=%h/%b want=9999/0", res[1], ovf[1]);
            end
            $display("test_back_to_back spacing=%0d res0=%h res1=%h", acc[1] - acc[0], res[0], res[1]);
        end
    endtask

    task automatic test_overflow();
        int vals [5] = '{12000, 42, 10000, 16383, 9999};
        int lat, rl;
        foreach (vals[i]) begin
            send(vals[i], 1, 1'b0, -1, lat, rl);
            checks++;
            if (lat !== 15 || bcd_out !== exp_bcd(vals[i]) || overflow !== (vals[i] > 9999)) begin
                failures++;
                $display("FAIL overflow_%0d got=%h/%b lat=%0d want=%h/%b", vals[i], bcd_out, overflow,
                         lat, exp_bcd(vals[i]), vals[i] > 9999);
            end
            $display("test_overflow in=%0d bcd=%h ovf=%b", vals[i], bcd_out, overflow);
        end
    endtask

    task automatic test_dp();
        int lat, rl;
        send(305, 2, 1'b1, -1, lat, rl);
        checks++;
        if (bcd_out !== 16'h0305 || decimal_points !== 4'b1011) begin
            failures++;
            $display("FAIL dp_305 got=%h/%b want=0305/1011", bcd_out, decimal_points);
        end
        $display("test_dp in=305 bcd=%h dp=%b", bcd_out, decimal_points);
    endtask

    task automatic test_input_change();
        int lat, rl;
        send(5678, 3, 1'b1, 7777, lat, rl);
        checks++;
        if (bcd_out !== 16'h5678 || decimal_points !== 4'b0111 || lat !== 15) begin
            failures++;
            $display("FAIL input_change got=%h/%b lat=%0d want=5678/0111", bcd_out, decimal_points, lat);
        end
        $display("test_input_change bcd=%h dp=%b", bcd_out, decimal_points);
    endtask

    task automatic test_reset_mid();
        int lat, rl;
        int pulses = 0;
        for (int i = 0; i < 40 && !bin_ready; i++) step();
        bin_in = 14'd6543; dp_sel = 2'd1; dp_en = 1'b1; bin_valid = 1'b1;
        step();
        bin_valid = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bcd_out !== 16'h0000 || decimal_points !== 4'hF || overflow !== 1'b0 ||
            bcd_valid !== 1'b0 || bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_values got=%h/%b/%b/%b/%b want=0000/1111/0/0/1",
                     bcd_out, decimal_points, overflow, bcd_valid, bin_ready);
        end
        repeat (3) begin step(); if (bcd_valid) pulses++; end
        rst_n = 1'b1;
        repeat (20) begin step(); if (bcd_valid) pulses++; end
        checks++;
        if (pulses !== 0 || bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_abort got=%0d/%b want=0/1", pulses, bin_ready);
        end
        send(4321, 0, 1'b1, -1, lat, rl);
        checks++;
        if (bcd_out !== 16'h4321 || decimal_points !== 4'b1110 || lat !== 15) begin
            failures++;
            $display("FAIL reset_mid_next got=%h/%b lat=%0d want=4321/1110", bcd_out, decimal_points, lat);
        end
        $display("test_reset_mid after=%h dp=%b", bcd_out, decimal_points);
    endtask

    task automatic test_random();
        int lat, rl, v, sel;
        bit en;
        for (int n = 0; n < 20; n++) begin
            v   = int'($urandom_range(0, 16383));
            sel = int'($urandom_range(0, 3));
            en  = 1'($urandom_range(0, 1));
            send(v, sel, en, -1, lat, rl);
            checks++;
            if (lat !== 15 || bcd_out !== exp_bcd(v) || decimal_points !== exp_dp(sel, en) ||
                overflow !== (v > 9999)) begin
                failures++;
                $display("FAIL random_%0d got=%h/%b/%b lat=%0d want=%h/%b/%b", v, bcd_out,
                         decimal_points, overflow, lat, exp_bcd(v), exp_dp(sel, en), v > 9999);
            end
            $display("test_random in=%0d sel=%0d en=%b bcd=%h dp=%b ovf=%b",
                     v, sel, en, bcd_out, decimal_points, overflow);
        end
    endtask

    initial begin
        repeat (2) step();
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_back_to_back();
        test_overflow();
        test_dp();
        test_input_change();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_convert_x_4.md
# bcd_convert_x_4

Sequential binary-to-BCD converter that feeds the 4-digit multiplexed seven-segment driver. It accepts a binary value over a valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) loop, one bit per clock. It presents four registered BCD digits plus active-low decimal-point enables, in exactly the format the display driver's `bcd_in` and `decimal_points` inputs take. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface
- `BIN_W`, 14: binary input width; fixed at 14 for 4 digits.
- `MAX_VAL`, 9999: saturation limit.
- Reset is asynchronous, active-low.
- `clk`  in  1  system clock (100 MHz board clock).
- `rst_n`  in  1  asynchronous active-low reset.
- `bin_in`  in  14  unsigned binary value to convert.
- `dp_sel`  in  2  digit index (0 = rightmost) whose decimal point lights.
- `dp_en`  in  1  1 = light the point at `dp_sel`; 0 = all points off.
- `bin_valid`  in  1  request; transfer occurs on an edge where `bin_valid` and `bin_ready` are both 1.
- `bin_ready`  out  1  high only in IDLE.
- `bcd_out`  out  16  digits; [3:0] units … [15:12] thousands. Registered.
- `decimal_points`  out  4  active-low one-hot; 1 = point off. Registered.
- `overflow`  out  1  last committed value was clamped. Registered.
- `bcd_valid`  out  1  one-cycle pulse when `bcd_out` updates.

## Operation
- FSM states: IDLE, CONV, DONE.
- **IDLE**
  - `bin_ready`=1.
  - On accept, capture into working registers: `min(bin_in, MAX_VAL)`, `dp_sel`, `dp_en`, and the flag `bin_in > MAX_VAL`.
  - Clear the 16-bit BCD scratch and the bit counter, then go to CONV.
- **CONV**
  - Each edge, every scratch nibble ≥5 gets +3, then {scratch, bin} shifts left by 1. The counter increments.
  - After the 14th shift (counter = 13 at that edge), go to DONE.
- **DONE**, one edge:
  - `bcd_out` ← scratch.
  - `decimal_points` ← `dp_en` ? ~(1 << `dp_sel`) : 4'b1111.
  - `overflow` ← captured flag.
  - `bcd_valid` ← 1.
  - Go to IDLE.
- `bcd_valid` is cleared on every other edge.
- Inputs are sampled only at the accept edge. Changes during CONV/DONE are ignored. `bin_valid` held high while busy does not queue a second request.
- Outputs hold their last committed value between conversions. The display never sees partial results.
- Arithmetic: each add-3 is 4-bit with no carry out; after clamping, no nibble can exceed 9.

## Timing
- Accept at edge N. Shifts on edges N+1…N+14. Commit at edge N+15.
- `bcd_out`/`bcd_valid` are visible in the cycle after N+15.
- `bin_ready` is low from after edge N until after N+15.
- Earliest next accept is edge N+16. Throughput is 1 conversion per 16 clocks.
- Reset values, asserted asynchronously on `rst_n` falling:
  - `bcd_out`=16'h0000, `decimal_points`=4'b1111, `overflow`=0, `bcd_valid`=0, `bin_ready`=1.
  - FSM=IDLE; counter and scratch = 0.
- Reset mid-conversion aborts it: no `bcd_valid` pulse, outputs return to reset values.
- First accept is possible on the first edge after `rst_n` deasserts.
- Boundary cases:
  - `bin_in`=0 gives 16'h0000.
  - `bin_in`=9999 gives 16'h9999 with `overflow`=0.
  - `bin_in`=10000…16383 gives 16'h9999 with `overflow`=1.

## Structure
- Shared package `display_pkg`:
  - `BCD_DIGITS`=4, `BIN_W`=14, `MAX_VAL`=9999.
  - FSM state encoding (IDLE/CONV/DONE).
  - `DP_OFF`=4'b1111.
- Sub-module `dabble_adjust`: combinational 4-bit nibble, +3 if ≥5. Instantiated 4× inside the CONV datapath.
- Top-level wiring: `bcd_out` → display `bcd_in`, `decimal_points` → display `decimal_points`.

## Test plan
- Reset, then `bin_in`=1234, `dp_en`=0, one-cycle valid → after 15 edges `bcd_out`=16'h1234, `decimal_points`=4'b1111, `bcd_valid` pulses exactly once, `bin_ready` low for 15 cycles.
- `bin_in`=0, then 9999 back-to-back with `bin_valid` held high → accepts 16 clocks apart; outputs 16'h0000, then 16'h9999, `overflow`=0 both times.
- `bin_in`=12000 → `bcd_out`=16'h9999, `overflow`=1. A following `bin_in`=42 → 16'h0042, `overflow`=0.
- `bin_in`=305, `dp_sel`=2, `dp_en`=1 → `bcd_out`=16'h0305, `decimal_points`=4'b1011.
- Change `bin_in` to 7777 during CONV after accepting 5678 → result is 16'h5678.
- Assert `rst_n`=0 at cycle 7 of a conversion → outputs immediately at reset values, no `bcd_valid`. After release, `bin_ready`=1 and the next conversion completes correctly.
